// File: rtl/id_stage_pipelined.sv
// Instruction decode stage with an integrated ID/EX pipeline register.
// Splits an ARM-style instruction into fields, reads the register file with
// a same-cycle write-back bypass, evaluates the condition code against NZCV
// and registers the decoded controls and operands for the EXE stage.
module id_stage_pipelined #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              hazard,
  input  logic              flush,
  input  logic              n,
  input  logic              z,
  input  logic              c,
  input  logic              v,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [3:0]        ex_opcode,
  output logic              ex_s,
  output logic              ex_imm,
  output logic              ex_mem_r,
  output logic              ex_mem_w,
  output logic              ex_branch,
  output logic              ex_wb_en,
  output logic [3:0]        ex_dest,
  output logic [11:0]       ex_shift_operand,
  output logic [23:0]       ex_simm24
);

  // ---------------------------------------------------------------------
  // Field extraction and control decode
  // ---------------------------------------------------------------------
  logic [1:0] mode;
  logic [3:0] opcode;
  logic [3:0] cond;
  logic       is_mem;
  logic       mem_r;
  logic       mem_w;
  logic       branch;
  logic       wb_en_dec;
  logic       cond_pass;
  logic       live;

  // Decode the instruction class and its memory/branch/write-back controls
  always_comb begin
    mode      = instr[27:26];
    opcode    = instr[24:21];
    cond      = instr[31:28];
    is_mem    = (mode == 2'b01);
    mem_r     = is_mem & instr[20];
    mem_w     = is_mem & ~instr[20];
    branch    = (mode == 2'b10);
    // TST/TEQ/CMP/CMN (opcodes 8..11) only update flags, never a register
    wb_en_dec = mem_r | ((mode == 2'b00) & (opcode[3:2] != 2'b10));
  end

  // Condition-code evaluation against the current NZCV flags
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = z;
      4'h1: cond_pass = ~z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = ~c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = ~n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = ~v;
      4'h8: cond_pass = c & ~z;
      4'h9: cond_pass = ~c | z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = ~z & (n == v);
      4'hD: cond_pass = z | (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;   // cond F never executes
    endcase
  end

  assign live = instr_valid & cond_pass;

  // Source indices go straight to the hazard unit; stores read Rd as data
  assign src1    = instr[19:16];
  assign src2    = mem_w ? instr[15:12] : instr[3:0];
  assign two_src = ~instr[25] | mem_w;

  // ---------------------------------------------------------------------
  // Register file: one slot per architectural index. Unimplemented slots
  // read as zero and have no storage, so writes to them vanish.
  // ---------------------------------------------------------------------
  logic [15:0][DATA_W-1:0] rd_arr;
  logic [15:0]             reg_impl;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rf
      if (gi < NUM_REGS) begin : g_impl
        logic [DATA_W-1:0] rf_q;
        logic [DATA_W-1:0] rf_d;

        // Next value: take the write-back data when this slot is addressed
        always_comb begin
          rf_d = rf_q;
          if (wb_en && (wb_dest == 4'(gi))) begin
            rf_d = wb_value;
          end
        end

        // Storage flop; cleared by reset so writes during reset are dropped
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            rf_q <= '0;
          end else begin
            rf_q <= rf_d;
          end
        end

        assign rd_arr[gi]   = rf_q;
        assign reg_impl[gi] = 1'b1;
      end else begin : g_none
        assign rd_arr[gi]   = '0;
        assign reg_impl[gi] = 1'b0;
      end
    end
  endgenerate

  logic [DATA_W-1:0] rn_val;
  logic [DATA_W-1:0] rm_val;

  // Operand read with same-cycle bypass of the write-back value
  always_comb begin
    rn_val = rd_arr[src1];
    rm_val = rd_arr[src2];
    if (wb_en && (wb_dest == src1) && reg_impl[src1]) begin
      rn_val = wb_value;
    end
    if (wb_en && (wb_dest == src2) && reg_impl[src2]) begin
      rm_val = wb_value;
    end
  end

  // ---------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------
  logic              ex_valid_q,  ex_valid_d;
  logic [PC_W-1:0]   ex_pc_q,     ex_pc_d;
  logic [DATA_W-1:0] ex_val_rn_q, ex_val_rn_d;
  logic [DATA_W-1:0] ex_val_rm_q, ex_val_rm_d;
  logic [3:0]        ex_opcode_q, ex_opcode_d;
  logic              ex_s_q,      ex_s_d;
  logic              ex_imm_q,    ex_imm_d;
  logic              ex_mem_r_q,  ex_mem_r_d;
  logic              ex_mem_w_q,  ex_mem_w_d;
  logic              ex_branch_q, ex_branch_d;
  logic              ex_wb_en_q,  ex_wb_en_d;
  logic [3:0]        ex_dest_q,   ex_dest_d;
  logic [11:0]       ex_shift_q,  ex_shift_d;
  logic [23:0]       ex_simm_q,   ex_simm_d;

  // Next state: flush or hazard insert a bubble (controls cleared, data
  // held); otherwise everything loads and a non-live slot carries no controls
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_pc_d     = ex_pc_q;
    ex_val_rn_d = ex_val_rn_q;
    ex_val_rm_d = ex_val_rm_q;
    ex_opcode_d = ex_opcode_q;
    ex_s_d      = ex_s_q;
    ex_imm_d    = ex_imm_q;
    ex_mem_r_d  = ex_mem_r_q;
    ex_mem_w_d  = ex_mem_w_q;
    ex_branch_d = ex_branch_q;
    ex_wb_en_d  = ex_wb_en_q;
    ex_dest_d   = ex_dest_q;
    ex_shift_d  = ex_shift_q;
    ex_simm_d   = ex_simm_q;
    if (flush || hazard) begin
      ex_valid_d  = 1'b0;
      ex_s_d      = 1'b0;
      ex_mem_r_d  = 1'b0;
      ex_mem_w_d  = 1'b0;
      ex_branch_d = 1'b0;
      ex_wb_en_d  = 1'b0;
    end else begin
      ex_valid_d  = live;
      ex_pc_d     = pc_in;
      ex_val_rn_d = rn_val;
      ex_val_rm_d = rm_val;
      ex_opcode_d = opcode;
      ex_imm_d    = instr[25];
      ex_dest_d   = instr[15:12];
      ex_shift_d  = instr[11:0];
      ex_simm_d   = instr[23:0];
      // S is meaningless for loads/stores and branches
      ex_s_d      = live & instr[20] & ~is_mem & ~branch;
      ex_mem_r_d  = live & mem_r;
      ex_mem_w_d  = live & mem_w;
      ex_branch_d = live & branch;
      ex_wb_en_d  = live & wb_en_dec;
    end
  end

  // Pipeline register flops, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_val_rn_q <= '0;
      ex_val_rm_q <= '0;
      ex_opcode_q <= '0;
      ex_s_q      <= 1'b0;
      ex_imm_q    <= 1'b0;
      ex_mem_r_q  <= 1'b0;
      ex_mem_w_q  <= 1'b0;
      ex_branch_q <= 1'b0;
      ex_wb_en_q  <= 1'b0;
      ex_dest_q   <= '0;
      ex_shift_q  <= '0;
      ex_simm_q   <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= ex_pc_d;
      ex_val_rn_q <= ex_val_rn_d;
      ex_val_rm_q <= ex_val_rm_d;
      ex_opcode_q <= ex_opcode_d;
      ex_s_q      <= ex_s_d;
      ex_imm_q    <= ex_imm_d;
      ex_mem_r_q  <= ex_mem_r_d;
      ex_mem_w_q  <= ex_mem_w_d;
      ex_branch_q <= ex_branch_d;
      ex_wb_en_q  <= ex_wb_en_d;
      ex_dest_q   <= ex_dest_d;
      ex_shift_q  <= ex_shift_d;
      ex_simm_q   <= ex_simm_d;
    end
  end

  assign ex_valid         = ex_valid_q;
  assign ex_pc            = ex_pc_q;
  assign ex_val_rn        = ex_val_rn_q;
  assign ex_val_rm        = ex_val_rm_q;
  assign ex_opcode        = ex_opcode_q;
  assign ex_s             = ex_s_q;
  assign ex_imm           = ex_imm_q;
  assign ex_mem_r         = ex_mem_r_q;
  assign ex_mem_w         = ex_mem_w_q;
  assign ex_branch        = ex_branch_q;
  assign ex_wb_en         = ex_wb_en_q;
  assign ex_dest          = ex_dest_q;
  assign ex_shift_operand = ex_shift_q;
  assign ex_simm24        = ex_simm_q;

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised next-generation instruction decode stage with an integrated ID/EX pipeline register.
- Splits the 32-bit ARM-style instruction into fields and reads a DATA_W-wide register file, with same-cycle WB bypass.
- Evaluates the condition code against NZCV. Derives memory, branch and write-back controls.
- Registers everything on stall/flush/bubble rules. Sits between the IF/ID register and the EXE stage; the hazard unit taps the combinational source indices.

Parameters:
- DATA_W, 32, register/operand width, 8..64.
- PC_W, 32, program counter width.
- NUM_REGS, 16, implemented registers, 2..16. Indices >= NUM_REGS read 0 and ignore writes.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- pc_in  in  PC_W  PC of the instruction in ID.
- instr  in  32  instruction word.
- instr_valid  in  1  instr holds a real instruction.
- hazard  in  1  insert a bubble this cycle.
- flush  in  1  kill the instruction in ID (taken branch).
- n, z, c, v  in  1 each  status flags.
- wb_en  in  1  register write enable.
- wb_dest  in  4  write index.
- wb_value  in  DATA_W  write data.
- src1  out  4  combinational Rn (instr[19:16]).
- src2  out  4  combinational: Rd when mem_w, else Rm.
- two_src  out  1  combinational ~instr[25] | mem_w.
- ex_valid  out  1  registered: EXE holds a live instruction.
- ex_pc  out  PC_W  registered PC.
- ex_val_rn, ex_val_rm  out  DATA_W  registered operands.
- ex_opcode  out  4  instr[24:21].
- ex_s  out  1  instr[20], forced 0 for memory and branch.
- ex_imm  out  1  instr[25].
- ex_mem_r, ex_mem_w, ex_branch, ex_wb_en  out  1 each  registered controls.
- ex_dest  out  4  instr[15:12].
- ex_shift_operand  out  12  instr[11:0].
- ex_simm24  out  24  instr[23:0].

Behaviour:
- Decode (combinational):
  - mode = instr[27:26]; mem_r = (mode==01) & instr[20]; mem_w = (mode==01) & ~instr[20]; branch = (mode==10).
  - wb_en_d = mem_r | ((mode==00) & opcode not in {1000 TST, 1001 TEQ, 1010 CMP, 1011 CMN}).
- Condition, cond = instr[31:28]:
  - 0 Z; 1 ~Z; 2 C; 3 ~C; 4 N; 5 ~N; 6 V; 7 ~V.
  - 8 C&~Z; 9 ~C|Z; A N==V; B N!=V; C ~Z&(N==V); D Z|(N!=V).
  - E 1; F 0.
- Register file:
  - NUM_REGS x DATA_W. Written on posedge clk when wb_en and wb_dest<NUM_REGS.
  - Read is combinational on src1/src2.
  - Bypass: if wb_en & wb_dest==index & index<NUM_REGS, the read returns wb_value in the same cycle.
- Pipeline register update on posedge clk, in priority order:
  - flush: ex_valid and all ex_ controls <= 0; data fields hold.
  - else hazard: same as flush (bubble).
  - else: all fields load. ex_valid <= instr_valid & cond_pass. When ex_valid loads 0, ex_mem_r, ex_mem_w, ex_branch, ex_wb_en and ex_s load 0.
- Latency: 1 cycle from instr to ex_ outputs. Throughput: 1 instruction/cycle.
- Reset (rst low, asynchronous):
  - All ex_ outputs go to 0, ex_pc included.
  - All registers go to 0.
  - A write presented during reset is dropped.
  - Operation resumes on the first rising edge after rst goes high.
- Outputs src1, src2 and two_src are valid even while hazard=1, so the hazard unit sees no loop latency.
- Simultaneous flush and hazard give a bubble. Simultaneous wb to the same index as a read use the bypass value.
- cond=F never executes.

Test Plan:
- Reset with rst=0 mid-stream: all ex_ outputs 0 immediately, without waiting for a clock edge. After release, a read of R3 returns 0.
- Bypass: wb_en=1, wb_dest=4, wb_value=0xDEADBEEF while instr reads Rn=4 -> ex_val_rn=0xDEADBEEF next cycle. R4 holds it afterwards.
- Condition: instr=0x0_0812003 (EQ ADD) with z=0 -> ex_valid=0 and ex_wb_en=0. With z=1 -> ex_valid=1, ex_wb_en=1, ex_dest=2.
- Store: instr=0xE5812004 (STR R2,[R1,#4]) -> src2=2, two_src=1, ex_mem_w=1, ex_wb_en=0.
- Hazard then flush: hazard=1 -> ex_valid=0 and ex_pc holds. flush=1 and hazard=1 together -> bubble. Next clean cycle loads normally.
- NUM_REGS=8: write R12=5, then read R12 -> 0. Write R7=9, then read R7 -> 9.
